// File: rtl/rptr_status.sv
// Read-side pointer and status block of an asynchronous FIFO.
// Keeps the binary/Gray read pointers and derives fill level, empty flags and sticky error flags.
module rptr_status #(
  parameter int ADDRSIZE  = 4,
  parameter int AEMPTY_TH = 2
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic                rinc,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  input  logic                rerr_clr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic                raempty,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                runderflow,
  output logic                rerr_range
);

  localparam logic [ADDRSIZE:0] DepthV   = (ADDRSIZE+1)'(2**ADDRSIZE);
  localparam logic [ADDRSIZE:0] AemptyTh = (ADDRSIZE+1)'(AEMPTY_TH);

  logic [ADDRSIZE:0] rbin_q, rbin_d;
  logic [ADDRSIZE:0] rgray_q, rgray_d;
  logic [ADDRSIZE:0] rlevel_q, rlevel_d;
  logic [ADDRSIZE:0] wbin_s;
  logic              rempty_q, rempty_d;
  logic              raempty_q, raempty_d;
  logic              runderflow_q, runderflow_d;
  logic              rerr_range_q, rerr_range_d;
  logic              pop_s;

  // Pops are qualified by the registered empty flag so a read while empty never moves the pointer.
  always_comb begin
    pop_s   = rinc & ~rempty_q;
    rbin_d  = rbin_q + {{ADDRSIZE{1'b0}}, pop_s};
    rgray_d = (rbin_d >> 1) ^ rbin_d;

    wbin_s = '0;
    for (int i = 0; i <= ADDRSIZE; i++) begin
      wbin_s = wbin_s ^ (rq2_wptr >> i);
    end

    rlevel_d  = wbin_s - rbin_d;
    rempty_d  = (rgray_d == rq2_wptr);
    raempty_d = (rlevel_d <= AemptyTh);

    // Sticky flags: a set condition on the same edge overrides a clear.
    runderflow_d = (rinc & rempty_q) | (runderflow_q & ~rerr_clr);
    rerr_range_d = (rlevel_d > DepthV) | (rerr_range_q & ~rerr_clr);
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rbin_q       <= '0;
      rgray_q      <= '0;
      rlevel_q     <= '0;
      rempty_q     <= 1'b1;
      raempty_q    <= 1'b1;
      runderflow_q <= 1'b0;
      rerr_range_q <= 1'b0;
    end else begin
      rbin_q       <= rbin_d;
      rgray_q      <= rgray_d;
      rlevel_q     <= rlevel_d;
      rempty_q     <= rempty_d;
      raempty_q    <= raempty_d;
      runderflow_q <= runderflow_d;
      rerr_range_q <= rerr_range_d;
    end
  end

  assign raddr      = rbin_q[ADDRSIZE-1:0];
  assign rptr       = rgray_q;
  assign rempty     = rempty_q;
  assign raempty    = raempty_q;
  assign rlevel     = rlevel_q;
  assign runderflow = runderflow_q;
  assign rerr_range = rerr_range_q;

endmodule

// File: tb/tb_rptr_status.sv
// Self-checking bench for rptr_status: directed scenarios plus a randomized phase,
// all compared against a counter-based reference model of the FIFO read side.
module tb_rptr_status;

  localparam int ADDRSIZE = 4;
  localparam int DEPTH    = 16;
  localparam int PTRMOD   = 32;
  localparam int AETH     = 2;

  logic                rclk;
  logic                rrst;
  logic                rinc;
  logic [ADDRSIZE:0]   rq2_wptr;
  logic                rerr_clr;
  logic [ADDRSIZE-1:0] raddr;
  logic [ADDRSIZE:0]   rptr;
  logic                rempty;
  logic                raempty;
  logic [ADDRSIZE:0]   rlevel;
  logic                runderflow;
  logic                rerr_range;

  int checks = 0;
  int errors = 0;
  bit clkEn  = 0;

  // Reference model state: plain integer read/write counts modulo the pointer range.
  int mRbin;
  int mLevel;
  bit mEmpty;
  bit mAempty;
  bit mUnder;
  bit mRange;
  int curWb;

  rptr_status #(.ADDRSIZE(ADDRSIZE), .AEMPTY_TH(AETH)) dut (
    .rclk(rclk), .rrst(rrst), .rinc(rinc), .rq2_wptr(rq2_wptr), .rerr_clr(rerr_clr),
    .raddr(raddr), .rptr(rptr), .rempty(rempty), .raempty(raempty), .rlevel(rlevel),
    .runderflow(runderflow), .rerr_range(rerr_range)
  );

  initial begin
    rclk = 1'b0;
    forever begin
      #5;
      if (clkEn) rclk = ~rclk;
    end
  end

  function automatic logic [ADDRSIZE:0] toGray(input int b);
    logic [ADDRSIZE:0] v;
    v = (ADDRSIZE+1)'(b % PTRMOD);
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mRbin = 0; mLevel = 0; mEmpty = 1; mAempty = 1; mUnder = 0; mRange = 0;
  endtask

  task automatic checkOutput(input string tag);
    chk({tag, ":raddr"},      32'(raddr),      32'(mRbin % DEPTH));
    chk({tag, ":rptr"},       32'(rptr),       32'(toGray(mRbin)));
    chk({tag, ":rlevel"},     32'(rlevel),     32'(mLevel));
    chk({tag, ":rempty"},     32'(rempty),     32'(mEmpty));
    chk({tag, ":raempty"},    32'(raempty),    32'(mAempty));
    chk({tag, ":runderflow"}, 32'(runderflow), 32'(mUnder));
    chk({tag, ":rerr_range"}, 32'(rerr_range), 32'(mRange));
  endtask

  // One clock: drive inputs at the falling edge, update the model, check at the next falling edge.
  task automatic applyStimulus(input bit r, input int wb, input bit c, input string tag);
    int pop;
    int lvl;
    curWb    = wb % PTRMOD;
    rinc     = r;
    rerr_clr = c;
    rq2_wptr = toGray(curWb);
    pop  = (r && !mEmpty) ? 1 : 0;
    if (r && mEmpty) mUnder = 1;
    else if (c)      mUnder = 0;
    mRbin = (mRbin + pop) % PTRMOD;
    lvl   = (curWb - mRbin + PTRMOD) % PTRMOD;
    if (lvl > DEPTH) mRange = 1;
    else if (c)      mRange = 0;
    mLevel  = lvl;
    mEmpty  = (lvl == 0);
    mAempty = (lvl <= AETH);
    @(posedge rclk);
    @(negedge rclk);
    checkOutput(tag);
  endtask

  initial begin
    int guard;
    int inc;
    rrst = 1'b0; rinc = 1'b0; rerr_clr = 1'b0; rq2_wptr = '0; curWb = 0;
    modelReset();

    $display("[TB] reset with clock stopped");
    #3 rrst = 1'b1;
    #2;
    checkOutput("reset_noclk");

    clkEn = 1;
    @(negedge rclk);
    rrst = 1'b0;
    applyStimulus(0, 0, 0, "idle");

    $display("[TB] fill then drain");
    for (int k = 1; k <= 5; k++) applyStimulus(0, k, 0, "fill");
    chk("fill5_level", 32'(rlevel), 32'd5);
    chk("fill5_aempty", 32'(raempty), 32'd0);
    for (int k = 0; k < 3; k++) applyStimulus(1, 5, 0, "pop3");
    chk("pop3_level", 32'(rlevel), 32'd2);
    chk("pop3_aempty", 32'(raempty), 32'd1);
    for (int k = 0; k < 2; k++) applyStimulus(1, 5, 0, "pop2");
    chk("drain_rptr", 32'(rptr), 32'b00111);
    chk("drain_empty", 32'(rempty), 32'd1);

    $display("[TB] underflow");
    applyStimulus(1, 5, 0, "uf_set");
    chk("uf_set_flag", 32'(runderflow), 32'd1);
    applyStimulus(1, 5, 1, "uf_setwins");
    chk("uf_setwins_flag", 32'(runderflow), 32'd1);
    applyStimulus(0, 5, 1, "uf_clr");
    chk("uf_clr_flag", 32'(runderflow), 32'd0);

    $display("[TB] advance read pointer to 30 with concurrent writes and pops");
    guard = 0;
    while ((mRbin != 30 || !mEmpty) && guard < 200) begin
      applyStimulus(!mEmpty, (curWb < 30) ? curWb + 1 : 30, 0, "advance");
      guard++;
    end
    chk("advance_reached", 32'(guard < 200), 32'd1);

    $display("[TB] pointer wrap");
    applyStimulus(0, 2, 0, "wrap_write");
    chk("wrap_write_level", 32'(rlevel), 32'd4);
    for (int k = 0; k < 4; k++) applyStimulus(1, 2, 0, "wrap_pop");
    chk("wrap_raddr", 32'(raddr), 32'd2);
    chk("wrap_rptr", 32'(rptr), 32'b00011);
    chk("wrap_empty", 32'(rempty), 32'd1);

    $display("[TB] simultaneous pop and write");
    applyStimulus(0, 5, 0, "sim_fill");
    chk("sim_fill_level", 32'(rlevel), 32'd3);
    applyStimulus(1, 6, 0, "sim_popwrite");
    chk("sim_level", 32'(rlevel), 32'd3);
    chk("sim_empty", 32'(rempty), 32'd0);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 300; n++) begin
      inc = $urandom_range(0, 2);
      if (mLevel + inc > DEPTH) inc = 0;
      applyStimulus(1'($urandom_range(0, 1)), curWb + inc, ($urandom_range(0, 7) == 0), "rand");
    end

    $display("[TB] mid-operation reset and range error");
    applyStimulus(0, curWb + 3, 0, "pre_reset");
    #2 rrst = 1'b1;
    #1;
    modelReset();
    checkOutput("async_reset");
    rq2_wptr = toGray(20);
    curWb    = 20;
    @(negedge rclk);
    rrst = 1'b0;
    checkOutput("reset_held");
    applyStimulus(0, 20, 0, "range_set");
    chk("range_flag", 32'(rerr_range), 32'd1);
    chk("range_level", 32'(rlevel), 32'd20);
    applyStimulus(0, 20, 1, "range_setwins");
    chk("range_setwins_flag", 32'(rerr_range), 32'd1);
    applyStimulus(0, 0, 1, "range_clr");
    chk("range_clr_flag", 32'(rerr_range), 32'd0);
    chk("range_clr_empty", 32'(rempty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
